vector_checker: RTL and testbench

// - Synthesisable stimulus/response harness: replays up to DEPTH stored input vectors to a DUT, one per cycle,
//   and compares the DUT output against stored expected values.
// - Generalises the per-gate truth-table sims: N-bit stimulus, M-bit response, pipelined DUTs, on-chip pass/fail.
// - Sits between a DUT and a host/loader; the host loads tables, pulses start, then reads pass/mismatch results.

---
 rtl/vector_checker_pkg.sv | 25 ++
 rtl/vector_checker_if.sv | 39 +++
 rtl/vec_delay_line.sv | 33 +++
 rtl/vector_checker.sv | 183 ++++++++++++++++++
 tb/tb_vector_checker.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vector_checker_pkg.sv
// Shared types and helpers for the vector_checker harness.
//   state_e      : run-control FSM states
//   MAX_LATENCY  : largest DUT latency the drain counter can cover
//   DRAIN_W      : width of the drain counter
//   sat_inc      : saturating increment for counters up to 32 bits wide
package vector_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MAX_LATENCY = 7;
  localparam int DRAIN_W     = 3;

  // Increment val, but never past the largest value a width-bit counter holds.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/vector_checker_if.sv
// Bus between the vector_checker and its host/DUT side.
//   Host -> checker : ld_en, ld_addr, ld_stim, ld_exp, run_len, start, abort
//   DUT  -> checker : resp
//   Checker -> DUT  : stim
//   Checker -> host : busy, done, pass, mismatch_cnt, first_fail
// master = host/DUT side, slave = the checker itself.
interface vector_checker_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 1,
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [IN_W-1:0]   ld_stim;
  logic [OUT_W-1:0]  ld_exp;
  logic [ADDR_W:0]   run_len;
  logic              start;
  logic              abort;
  logic [IN_W-1:0]   stim;
  logic [OUT_W-1:0]  resp;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [ADDR_W-1:0] first_fail;

  modport master (
    output ld_en, ld_addr, ld_stim, ld_exp, run_len, start, abort, resp,
    input  stim, busy, done, pass, mismatch_cnt, first_fail
  );

  modport slave (
    input  ld_en, ld_addr, ld_stim, ld_exp, run_len, start, abort, resp,
    output stim, busy, done, pass, mismatch_cnt, first_fail
  );
endinterface

// File: rtl/vec_delay_line.sv
// N-stage shift register with synchronous clear; N=0 is a plain wire.
//   clk : clock
//   clr : synchronous clear of every stage
//   d   : data into stage 0
//   q   : data out of the last stage
module vec_delay_line #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (N == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] stage_q [N];

    always_ff @(posedge clk) begin
      if (clr) begin
        for (int i = 0; i < N; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[N-1];
  end

endmodule

// File: rtl/vector_checker.sv
// Synthesisable stimulus/response harness. The host loads stimulus/expected
// tables, pulses start; the checker plays run_len vectors to the DUT one per
// cycle, compares the DUT response LATENCY cycles later, and reports
// pass / mismatch_cnt / first_fail once done.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : vector_checker_if slave modport (load port, control, stim/resp, results)
module vector_checker
  import vector_checker_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 1,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  vector_checker_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int DL_W   = 1 + OUT_W + ADDR_W;
  localparam logic [LEN_W-1:0]   DEPTH_L = LEN_W'(DEPTH);
  localparam logic [DRAIN_W-1:0] LAT_L   = DRAIN_W'(LATENCY);

  // Vector tables: one write port (host load), one read port (playback).
  logic [IN_W-1:0]  stim_mem [DEPTH];
  logic [OUT_W-1:0] exp_mem  [DEPTH];

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [IN_W-1:0]    stim_q, stim_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  ff_q, ff_d;

  logic              can_load, start_hit, abort_hit, issue, last_issue, ld_ok;
  logic [LEN_W-1:0]  len_req;
  logic [DL_W-1:0]   dl_in, dl_out;
  logic              dl_valid, mismatch;
  logic [OUT_W-1:0]  dl_exp;
  logic [ADDR_W-1:0] dl_idx;

  assign can_load   = (state_q == IDLE) || (state_q == DONE);
  // abort beats start, so a simultaneous start is simply dropped.
  assign start_hit  = bus.start && !bus.abort && can_load;
  assign abort_hit  = bus.abort && (state_q != IDLE);
  assign issue      = (state_q == RUN);
  assign last_issue = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign ld_ok      = bus.ld_en && can_load && ({1'b0, bus.ld_addr} < DEPTH_L);

  // Requested length folded into 1..DEPTH.
  always_comb begin
    len_req = bus.run_len;
    if (bus.run_len == '0)          len_req = LEN_W'(1);
    else if (bus.run_len > DEPTH_L) len_req = DEPTH_L;
  end

  // {valid, expected, index} rides alongside the issued vector. One extra stage
  // lines it up with stim_q; the remaining LATENCY stages match the DUT pipe.
  assign dl_in = issue ? {1'b1, exp_mem[idx_q], idx_q} : '0;

  vec_delay_line #(
    .W (DL_W),
    .N (LATENCY + 1)
  ) u_delay (
    .clk (clk),
    .clr (!rst_n || abort_hit),
    .d   (dl_in),
    .q   (dl_out)
  );

  assign {dl_valid, dl_exp, dl_idx} = dl_out;
  assign mismatch = dl_valid && (bus.resp != dl_exp);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    drain_d = drain_q;
    stim_d  = '0;
    cnt_d   = cnt_q;
    ff_d    = ff_q;

    if (mismatch) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
      if (cnt_q == '0) ff_d = dl_idx;
    end

    case (state_q)
      RUN: begin
        stim_d = stim_mem[idx_q];
        if (last_issue) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      // Last vector's compare lands LATENCY+1 edges after it was issued.
      DRAIN: begin
        if (drain_q == LAT_L) state_d = DONE;
        else                  drain_d = drain_q + DRAIN_W'(1);
      end
      default: ;
    endcase

    if (start_hit) begin
      state_d = RUN;
      idx_d   = '0;
      len_d   = len_req;
      drain_d = '0;
      cnt_d   = '0;
      ff_d    = '0;
    end

    if (abort_hit) begin
      state_d = IDLE;
      idx_d   = '0;
      drain_d = '0;
      stim_d  = '0;
      cnt_d   = '0;
      ff_d    = '0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (cnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      drain_q <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      drain_q <= drain_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      ff_q    <= ff_d;
    end
  end

  // NOTE: table storage has no reset; the host always loads before a run, and
  // leaving it unreset lets it map onto plain register/RAM arrays.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      stim_mem[bus.ld_addr] <= bus.ld_stim;
      exp_mem[bus.ld_addr]  <= bus.ld_exp;
    end
  end

  assign bus.stim         = stim_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_cnt = cnt_q;
  assign bus.first_fail   = ff_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker. Four checkers share one host bus:
//   u0 : LATENCY=0, CNT_W=8, combinational NAND DUT
//   u1 : LATENCY=2, CNT_W=8, NAND + 2 registers
//   u2 : LATENCY=1, CNT_W=8, NAND + 2 registers (latency mis-set)
//   u3 : LATENCY=0, CNT_W=2, combinational NAND DUT
module tb_vector_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ld_en = 1'b0;
  logic [3:0] ld_addr = '0;
  logic [1:0] ld_stim = '0;
  logic       ld_exp = 1'b0;
  logic [4:0] run_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;

  int total = 0;
  int bad = 0;

  int         done_at [4];
  logic [1:0] stim_log [24];
  logic       busy_log [24];
  logic [7:0] cnt_log [24];

  vector_checker_if #(.IN_W(2), .OUT_W(1), .DEPTH(16), .CNT_W(8)) if0 ();
  vector_checker_if #(.IN_W(2), .OUT_W(1), .DEPTH(16), .CNT_W(8)) if1 ();
  vector_checker_if #(.IN_W(2), .OUT_W(1), .DEPTH(16), .CNT_W(8)) if2 ();
  vector_checker_if #(.IN_W(2), .OUT_W(1), .DEPTH(16), .CNT_W(2)) if3 ();

  assign if0.ld_en = ld_en;   assign if1.ld_en = ld_en;   assign if2.ld_en = ld_en;   assign if3.ld_en = ld_en;
  assign if0.ld_addr = ld_addr; assign if1.ld_addr = ld_addr; assign if2.ld_addr = ld_addr; assign if3.ld_addr = ld_addr;
  assign if0.ld_stim = ld_stim; assign if1.ld_stim = ld_stim; assign if2.ld_stim = ld_stim; assign if3.ld_stim = ld_stim;
  assign if0.ld_exp = ld_exp; assign if1.ld_exp = ld_exp; assign if2.ld_exp = ld_exp; assign if3.ld_exp = ld_exp;
  assign if0.run_len = run_len; assign if1.run_len = run_len; assign if2.run_len = run_len; assign if3.run_len = run_len;
  assign if0.start = start;   assign if1.start = start;   assign if2.start = start;   assign if3.start = start;
  assign if0.abort = abort;   assign if1.abort = abort;   assign if2.abort = abort;   assign if3.abort = abort;

  // DUT models
  logic p1a = 1'b1, p2a = 1'b1, p1b = 1'b1, p2b = 1'b1;
  always @(posedge clk) begin
    p1a <= ~&if1.stim;
    p2a <= p1a;
    p1b <= ~&if2.stim;
    p2b <= p1b;
  end
  assign if0.resp = ~&if0.stim;
  assign if3.resp = ~&if3.stim;
  assign if1.resp = p2a;
  assign if2.resp = p2b;

  vector_checker #(.IN_W(2), .OUT_W(1), .DEPTH(16), .LATENCY(0), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  vector_checker #(.IN_W(2), .OUT_W(1), .DEPTH(16), .LATENCY(2), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  vector_checker #(.IN_W(2), .OUT_W(1), .DEPTH(16), .LATENCY(1), .CNT_W(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  vector_checker #(.IN_W(2), .OUT_W(1), .DEPTH(16), .LATENCY(0), .CNT_W(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  task automatic load(input logic [3:0] a, input logic [1:0] s, input logic e);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_stim = s; ld_exp = e;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_nand_table(input logic e2);
    load(4'd0, 2'd0, 1'b1);
    load(4'd1, 2'd1, 1'b1);
    load(4'd2, 2'd2, e2);
    load(4'd3, 2'd3, 1'b0);
  endtask

  // Pulse start, then log 23 cycles. Cycle c is sampled at the negedge after
  // the c-th rising edge following the start edge. mode: 0 plain,
  // 1 start+load while busy, 2 abort, 3 reset -- each held for the edge into cycle 3.
  task automatic run(input logic [4:0] len, input int mode);
    for (int k = 0; k < 4; k++) done_at[k] = -1;
    @(negedge clk);
    run_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stim_log[0] = if0.stim; busy_log[0] = if0.busy; cnt_log[0] = if0.mismatch_cnt;
    for (int c = 1; c < 24; c++) begin
      @(negedge clk);
      stim_log[c] = if0.stim; busy_log[c] = if0.busy; cnt_log[c] = if0.mismatch_cnt;
      if (done_at[0] < 0 && if0.done) done_at[0] = c;
      if (done_at[1] < 0 && if1.done) done_at[1] = c;
      if (done_at[2] < 0 && if2.done) done_at[2] = c;
      if (done_at[3] < 0 && if3.done) done_at[3] = c;
      if (c == 2) begin
        case (mode)
          1: begin start = 1'b1; run_len = 5'd1; ld_en = 1'b1; ld_addr = 4'd3; ld_stim = 2'd3; ld_exp = 1'b1; end
          2: abort = 1'b1;
          3: rst_n = 1'b0;
          default: ;
        endcase
      end else if (c == 3) begin
        start = 1'b0; abort = 1'b0; rst_n = 1'b1; ld_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (if0.stim !== 2'd0) begin bad++; $display("FAIL reset.stim: got %0d want 0", if0.stim); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset.busy: got %b want 0", if0.busy); end
    total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL reset.done: got %b want 0", if0.done); end
    total++; if (if0.pass !== 1'b0) begin bad++; $display("FAIL reset.pass: got %b want 0", if0.pass); end
    total++; if (if0.mismatch_cnt !== 8'd0) begin bad++; $display("FAIL reset.cnt: got %0d want 0", if0.mismatch_cnt); end
    total++; if (if0.first_fail !== 4'd0) begin bad++; $display("FAIL reset.first_fail: got %0d want 0", if0.first_fail); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin bad++; $display("FAIL reset.u1_idle: got busy=%b done=%b want 0 0", if1.busy, if1.done); end
  endtask

  task automatic test_nand_pass();
    load_nand_table(1'b1);
    run(5'd4, 0);
    for (int c = 1; c <= 5; c++) begin
      logic [1:0] want;
      want = (c <= 4) ? 2'(c - 1) : 2'd0;
      total++; if (stim_log[c] !== want) begin bad++; $display("FAIL nand_pass.stim[%0d]: got %0d want %0d", c, stim_log[c], want); end
    end
    total++; if (busy_log[1] !== 1'b1 || busy_log[4] !== 1'b1 || busy_log[5] !== 1'b0) begin bad++; $display("FAIL nand_pass.busy: got %b%b%b want 110", busy_log[1], busy_log[4], busy_log[5]); end
    total++; if (done_at[0] != 5) begin bad++; $display("FAIL nand_pass.done_at: got %0d want 5", done_at[0]); end
    total++; if (if0.pass !== 1'b1 || if0.mismatch_cnt !== 8'd0) begin bad++; $display("FAIL nand_pass.result: got pass=%b cnt=%0d want 1 0", if0.pass, if0.mismatch_cnt); end
    total++; if (done_at[1] != 7) begin bad++; $display("FAIL lat2.done_at: got %0d want 7", done_at[1]); end
    total++; if (if1.pass !== 1'b1) begin bad++; $display("FAIL lat2.pass: got %b want 1", if1.pass); end
    total++; if (done_at[2] != 6) begin bad++; $display("FAIL lat1.done_at: got %0d want 6", done_at[2]); end
    total++; if (if2.pass !== 1'b0 || if2.mismatch_cnt !== 8'd1 || if2.first_fail !== 4'd3) begin bad++; $display("FAIL lat1.result: got pass=%b cnt=%0d ff=%0d want 0 1 3", if2.pass, if2.mismatch_cnt, if2.first_fail); end
    // abort from DONE clears the results
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (if0.done !== 1'b0 || if0.pass !== 1'b0 || if0.busy !== 1'b0) begin bad++; $display("FAIL abort_done: got done=%b pass=%b busy=%b want 0 0 0", if0.done, if0.pass, if0.busy); end
  endtask

  task automatic test_one_mismatch();
    load(4'd2, 2'd2, 1'b0);
    run(5'd4, 0);
    total++; if (done_at[0] != 5) begin bad++; $display("FAIL mismatch.done_at: got %0d want 5", done_at[0]); end
    total++; if (if0.pass !== 1'b0 || if0.mismatch_cnt !== 8'd1 || if0.first_fail !== 4'd2) begin bad++; $display("FAIL mismatch.result: got pass=%b cnt=%0d ff=%0d want 0 1 2", if0.pass, if0.mismatch_cnt, if0.first_fail); end
    total++; if (if2.mismatch_cnt !== 8'd2 || if2.first_fail !== 4'd2) begin bad++; $display("FAIL mismatch.lat1: got cnt=%0d ff=%0d want 2 2", if2.mismatch_cnt, if2.first_fail); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 16; i++) load(4'(i), 2'(i), &(2'(i)));
    run(5'd31, 0);
    total++; if (done_at[0] != 17) begin bad++; $display("FAIL sat.done_at: got %0d want 17", done_at[0]); end
    total++; if (if0.mismatch_cnt !== 8'd16 || if0.first_fail !== 4'd0) begin bad++; $display("FAIL sat.u0: got cnt=%0d ff=%0d want 16 0", if0.mismatch_cnt, if0.first_fail); end
    total++; if (if3.mismatch_cnt !== 2'd3 || if3.first_fail !== 4'd0 || if3.pass !== 1'b0) begin bad++; $display("FAIL sat.u3: got cnt=%0d ff=%0d pass=%b want 3 0 0", if3.mismatch_cnt, if3.first_fail, if3.pass); end
    total++; if (done_at[1] != 19) begin bad++; $display("FAIL sat.lat2_done_at: got %0d want 19", done_at[1]); end
  endtask

  task automatic test_busy_ignore();
    load_nand_table(1'b1);
    run(5'd4, 1);
    total++; if (done_at[0] != 5) begin bad++; $display("FAIL busy_ign.done_at: got %0d want 5", done_at[0]); end
    total++; if (stim_log[4] !== 2'd3 || stim_log[5] !== 2'd0) begin bad++; $display("FAIL busy_ign.stim: got %0d,%0d want 3,0", stim_log[4], stim_log[5]); end
    total++; if (if0.pass !== 1'b1 || if0.mismatch_cnt !== 8'd0) begin bad++; $display("FAIL busy_ign.result: got pass=%b cnt=%0d want 1 0", if0.pass, if0.mismatch_cnt); end
  endtask

  task automatic test_abort();
    load(4'd0, 2'd0, 1'b0);
    run(5'd4, 2);
    total++; if (cnt_log[2] !== 8'd1) begin bad++; $display("FAIL abort.cnt_before: got %0d want 1", cnt_log[2]); end
    total++; if (stim_log[3] !== 2'd0 || busy_log[3] !== 1'b0) begin bad++; $display("FAIL abort.idle: got stim=%0d busy=%b want 0 0", stim_log[3], busy_log[3]); end
    total++; if (cnt_log[3] !== 8'd0 || done_at[0] != -1) begin bad++; $display("FAIL abort.cleared: got cnt=%0d done_at=%0d want 0 -1", cnt_log[3], done_at[0]); end
    total++; if (if0.done !== 1'b0 || if0.first_fail !== 4'd0) begin bad++; $display("FAIL abort.final: got done=%b ff=%0d want 0 0", if0.done, if0.first_fail); end
  endtask

  task automatic test_reset_mid();
    load(4'd0, 2'd0, 1'b1);
    run(5'd4, 3);
    total++; if (stim_log[3] !== 2'd0 || busy_log[3] !== 1'b0 || done_at[0] != -1) begin bad++; $display("FAIL rst_mid.idle: got stim=%0d busy=%b done_at=%0d want 0 0 -1", stim_log[3], busy_log[3], done_at[0]); end
    run(5'd4, 0);
    total++; if (done_at[0] != 5 || if0.pass !== 1'b1) begin bad++; $display("FAIL rst_mid.rerun: got done_at=%0d pass=%b want 5 1", done_at[0], if0.pass); end
    total++; if (done_at[1] != 7 || if1.pass !== 1'b1) begin bad++; $display("FAIL rst_mid.lat2: got done_at=%0d pass=%b want 7 1", done_at[1], if1.pass); end
  endtask

  task automatic test_run_len_zero();
    load(4'd0, 2'd3, 1'b0);
    run(5'd0, 0);
    total++; if (stim_log[1] !== 2'd3 || stim_log[2] !== 2'd0) begin bad++; $display("FAIL len0.stim: got %0d,%0d want 3,0", stim_log[1], stim_log[2]); end
    total++; if (done_at[0] != 2) begin bad++; $display("FAIL len0.done_at: got %0d want 2", done_at[0]); end
    total++; if (if0.pass !== 1'b1) begin bad++; $display("FAIL len0.pass: got %b want 1", if0.pass); end
    total++; if (done_at[1] != 4 || if1.pass !== 1'b1) begin bad++; $display("FAIL len0.lat2: got done_at=%0d pass=%b want 4 1", done_at[1], if1.pass); end
  endtask

  initial begin
    test_reset();
    test_nand_pass();
    test_one_mismatch();
    test_saturate();
    test_busy_ignore();
    test_abort();
    test_reset_mid();
    test_run_len_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
